// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multi-cycle sequencer for the RV32I core. Each instruction is stepped
//   through FETCH/DECODE/EXEC/MEM/WB. The controller drives the datapath mux
//   selects, the write strobes and alu_op (which feeds alu_control). It also
//   handshakes with the single shared instruction/data memory port.
//   The controller halts in TRAP on an illegal opcode or a memory timeout.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode[6:0]     instr[6:0] from IR, valid from DECODE onward
//   branch_taken    comparator result, used in EXEC for BRANCH
//   mem_ready       memory completes the current request this cycle
//   mem_req/mem_we  memory request / store strobe
//   mem_addr_sel    0=PC, 1=ALU result
//   ir_we, pc_we    IR load, PC update
//   pc_sel[1:0]     00=PC+4, 01=PC+imm, 10=ALU&~1
//   reg_we          regfile write
//   wb_sel[1:0]     00=ALU, 01=mem, 10=PC+4, 11=imm
//   alu_op[1:0]     00=ADD, 01=SUB/cmp, 10=R-type, 11=I-type
//   alu_src_a/b     0=rs1/rs2, 1=PC/imm
//   halted, bus_err in TRAP / TRAP caused by timeout (sticky)
//   instret[31:0]   retired instruction count
//
// state  | meaning
// FETCH  | read instruction at PC, wait for mem_ready
// DECODE | latch instruction class, reject illegal opcodes
// EXEC   | ALU operation; BRANCH retires here
// MEM    | load/store data access; STORE retires here
// WB     | register writeback and PC update, retire
// TRAP   | halted until reset
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] instret
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP
  } cls_t;

  state_t        state, state_n;
  cls_t          cls, dec_cls;
  logic [CW-1:0] cnt;
  logic          bus_err_q;
  logic [31:0]   instret_q;
  logic          retire, set_bus_err, timeout_hit;
  logic [1:0]    alu_op_c;
  logic          src_a_c, src_b_c;

  always_comb begin
    dec_cls = C_NONE;
    case (opcode)
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1100011: dec_cls = C_BRANCH;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b0010011: dec_cls = C_OPIMM;
      7'b0110011: dec_cls = C_OP;
      default:    dec_cls = C_NONE;
    endcase
  end

  // ALU control derived from the latched class; held through MEM and WB.
  always_comb begin
    alu_op_c = 2'b00;
    src_a_c  = 1'b0;
    src_b_c  = 1'b0;
    case (cls)
      C_OP:     alu_op_c = 2'b10;
      C_OPIMM:  begin alu_op_c = 2'b11; src_b_c = 1'b1; end
      C_LOAD,
      C_STORE,
      C_JALR:   src_b_c = 1'b1;
      C_AUIPC:  begin src_a_c = 1'b1; src_b_c = 1'b1; end
      C_BRANCH: alu_op_c = 2'b01;
      default:  ;
    endcase
  end

  // cnt holds the remaining wait budget; zero means this is the last
  // allowed cycle without mem_ready.
  assign timeout_hit = (cnt == '0);

  always_comb begin
    state_n      = state;
    retire       = 1'b0;
    set_bus_err  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    alu_op       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_n = S_DECODE;
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_n     = S_TRAP;
        end
      end
      S_DECODE: begin
        state_n = (dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        alu_op    = alu_op_c;
        alu_src_a = src_a_c;
        alu_src_b = src_b_c;
        case (cls)
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = branch_taken ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_n = S_FETCH;
          end
          C_LOAD, C_STORE: state_n = S_MEM;
          default:         state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == C_STORE);
        alu_op       = alu_op_c;
        alu_src_a    = src_a_c;
        alu_src_b    = src_b_c;
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (timeout_hit) begin
          set_bus_err = 1'b1;
          state_n     = S_TRAP;
        end
      end
      S_WB: begin
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        alu_op    = alu_op_c;
        alu_src_a = src_a_c;
        alu_src_b = src_b_c;
        case (cls)
          C_LOAD:  wb_sel = 2'b01;
          C_JAL:   begin wb_sel = 2'b10; pc_sel = 2'b01; end
          C_JALR:  begin wb_sel = 2'b10; pc_sel = 2'b10; end
          C_LUI:   wb_sel = 2'b11;
          default: ;
        endcase
        state_n = S_FETCH;
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: state_n = S_TRAP;
    endcase

    // Reset overrides every strobe and select, even mid-transaction.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 2'b00;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
      alu_op       = 2'b00;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      halted       = 1'b0;
      retire       = 1'b0;
      set_bus_err  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      cls       <= C_NONE;
      cnt       <= CNT_LOAD;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE)
        cls <= dec_cls;
      if ((state_n == S_FETCH || state_n == S_MEM) && state_n != state)
        cnt <= CNT_LOAD;
      else if ((state == S_FETCH || state == S_MEM) && !mem_ready && !timeout_hit)
        cnt <= cnt - 1'b1;
      if (set_bus_err)
        bus_err_q <= 1'b1;
      if (retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign bus_err = bus_err_q;
  assign instret = instret_q;

endmodule
